// File: rtl/llr_intri_loader_pkg.sv
// rtl/llr_intri_loader_pkg.sv - shared widths, bank-state encoding and saturation helpers
package llr_intri_loader_pkg;

  localparam int LLR_WIDTH_DEF  = 8;
  localparam int ADDR_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    BANK_FREE = 2'd0,
    BANK_FULL = 2'd1,
    BANK_BUSY = 2'd2
  } bank_state_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } fill_state_e;

  function automatic int sat_max(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

  localparam int LLR_SAT_MAX = sat_max(LLR_WIDTH_DEF);

endpackage

// File: rtl/llr_intri_loader_sat.sv
// rtl/llr_intri_loader_sat.sv - symmetric two's-complement clipper, IN_WIDTH to LLR_WIDTH
module llr_sat
  import llr_intri_loader_pkg::*;
#(
  parameter int IN_WIDTH  = 12,
  parameter int LLR_WIDTH = LLR_WIDTH_DEF
) (
  input  logic signed [IN_WIDTH-1:0]  llr_i,
  output logic signed [LLR_WIDTH-1:0] llr_o
);

  // The most negative code is excluded so the stored range stays symmetric.
  localparam logic signed [IN_WIDTH-1:0] MAX_IN = IN_WIDTH'(sat_max(LLR_WIDTH));
  localparam logic signed [IN_WIDTH-1:0] MIN_IN = -MAX_IN;

  always_comb begin
    if (llr_i > MAX_IN) begin
      llr_o = MAX_IN[LLR_WIDTH-1:0];
    end else if (llr_i < MIN_IN) begin
      llr_o = MIN_IN[LLR_WIDTH-1:0];
    end else begin
      llr_o = llr_i[LLR_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/llr_intri_loader.sv
// rtl/llr_intri_loader.sv - ping-pong loader writing saturated channel LLRs into the intrinsic RAM
module llr_intri_loader
  import llr_intri_loader_pkg::*;
#(
  parameter int LLR_WIDTH  = LLR_WIDTH_DEF,
  parameter int IN_WIDTH   = 12,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int FRAME_LEN  = 96
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [IN_WIDTH-1:0]   in_llr_i,
  input  logic                  in_last_i,
  output logic                  wren_o,
  output logic [ADDR_WIDTH-1:0] wraddress_o,
  output logic [LLR_WIDTH-1:0]  data_o,
  output logic                  frame_valid_o,
  output logic                  frame_bank_o,
  input  logic                  frame_ready_i,
  input  logic                  dec_release_i,
  output logic                  err_len_o
);

  localparam int IDX_W = ADDR_WIDTH - 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  fill_state_e          state_q;
  bank_state_e          bank_q [2];
  bank_state_e          bank_d [2];
  logic                 wr_bank_q, rd_bank_q, rel_bank_q;
  logic                 rd_bank_d;
  logic [IDX_W-1:0]     idx_q;
  logic                 wren_q, frame_valid_q, frame_valid_d, frame_bank_q, err_len_q;
  logic [ADDR_WIDTH-1:0] wraddress_q;
  logic [LLR_WIDTH-1:0] data_q;
  logic [LLR_WIDTH-1:0] sat_llr;
  logic                 accept, at_last, commit, take, release_ok;

  llr_sat #(
    .IN_WIDTH  (IN_WIDTH),
    .LLR_WIDTH (LLR_WIDTH)
  ) u_sat (
    .llr_i (in_llr_i),
    .llr_o (sat_llr)
  );

  assign in_ready_o = (state_q == ST_FILL);

  // Banks are taken and released in order, so the oldest BUSY bank is tracked by a toggling pointer.
  always_comb begin
    accept     = in_valid_i && in_ready_o;
    at_last    = (idx_q == LAST_IDX);
    commit     = accept && at_last;
    take       = frame_valid_q && frame_ready_i;
    release_ok = dec_release_i && (bank_q[rel_bank_q] == BANK_BUSY);
    bank_d     = bank_q;
    if (commit)     bank_d[wr_bank_q]  = BANK_FULL;
    if (take)       bank_d[rd_bank_q]  = BANK_BUSY;
    if (release_ok) bank_d[rel_bank_q] = BANK_FREE;
    rd_bank_d     = rd_bank_q ^ take;
    // A bank committed this cycle is offered one cycle later, once its last RAM write has landed.
    frame_valid_d = (bank_d[rd_bank_d] == BANK_FULL) && !(commit && (wr_bank_q == rd_bank_d));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      bank_q        <= '{default: BANK_FREE};
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      rel_bank_q    <= 1'b0;
      idx_q         <= '0;
      wren_q        <= 1'b0;
      wraddress_q   <= '0;
      data_q        <= '0;
      frame_valid_q <= 1'b0;
      frame_bank_q  <= 1'b0;
      err_len_q     <= 1'b0;
    end else begin
      bank_q        <= bank_d;
      rd_bank_q     <= rd_bank_d;
      rel_bank_q    <= rel_bank_q ^ release_ok;
      frame_valid_q <= frame_valid_d;
      frame_bank_q  <= rd_bank_d;
      wren_q        <= accept;
      err_len_q     <= 1'b0;
      if (accept) begin
        wraddress_q <= {wr_bank_q, idx_q};
        data_q      <= sat_llr;
      end
      case (state_q)
        ST_IDLE: begin
          if (bank_q[wr_bank_q] == BANK_FREE) state_q <= ST_FILL;
        end
        ST_FILL: begin
          if (accept) begin
            if (at_last) begin
              err_len_q <= !in_last_i;
              idx_q     <= '0;
              wr_bank_q <= !wr_bank_q;
              state_q   <= ST_IDLE;
            end else if (in_last_i) begin
              // Short frame: restart the same bank from index 0.
              err_len_q <= 1'b1;
              idx_q     <= '0;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign wren_o        = wren_q;
  assign wraddress_o   = wraddress_q;
  assign data_o        = data_q;
  assign frame_valid_o = frame_valid_q;
  assign frame_bank_o  = frame_bank_q;
  assign err_len_o     = err_len_q;

endmodule

// File: tb/tb_llr_intri_loader.sv
// tb/tb_llr_intri_loader.sv - scoreboard bench for llr_intri_loader
module tb_llr_intri_loader;

  localparam int FRAME_LEN = 96;
  localparam int BANK_SPAN = 128;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] in_llr = '0;
  logic        in_last = 1'b0;
  logic        wren;
  logic [7:0]  wraddress;
  logic [7:0]  data;
  logic        frame_valid;
  logic        frame_bank;
  logic        frame_ready = 1'b0;
  logic        dec_release = 1'b0;
  logic        err_len;

  llr_intri_loader dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .in_llr_i      (in_llr),
    .in_last_i     (in_last),
    .wren_o        (wren),
    .wraddress_o   (wraddress),
    .data_o        (data),
    .frame_valid_o (frame_valid),
    .frame_bank_o  (frame_bank),
    .frame_ready_i (frame_ready),
    .dec_release_i (dec_release),
    .err_len_o     (err_len)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t exp_wr[$];
  int  exp_fr[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  int  exp_err  = 0;
  int  obs_err  = 0;
  int  wr_m     = 0;
  int  idx_m    = 0;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
  endtask

  function automatic int sat(input int v);
    if (v > 127) return 127;
    if (v < -127) return -127;
    return v;
  endfunction

  function automatic void model_accept(input int v, input bit last);
    wr_t w;
    w.addr = wr_m * BANK_SPAN + idx_m;
    w.data = sat(v);
    exp_wr.push_back(w);
    if (idx_m == FRAME_LEN - 1) begin
      exp_fr.push_back(wr_m);
      if (!last) exp_err++;
      idx_m = 0;
      wr_m  = 1 - wr_m;
    end else if (last) begin
      exp_err++;
      idx_m = 0;
    end else begin
      idx_m++;
    end
  endfunction

  // Monitor: every write and every frame handshake is checked against the queues.
  always @(negedge clk) begin
    if (wren) begin
      if (exp_wr.size() == 0) check("unexpected_write", 1, 0);
      else begin
        wr_t w;
        w = exp_wr.pop_front();
        check("wraddress", int'(wraddress), w.addr);
        check("data", int'($signed(data)), w.data);
      end
    end
    if (err_len) obs_err++;
    if (frame_valid && frame_ready) begin
      if (exp_fr.size() == 0) check("unexpected_frame", 1, 0);
      else check("frame_bank", int'(frame_bank), exp_fr.pop_front());
    end
  end

  // All drives happen 1ns after a rising edge; tasks return at that same point.
  task automatic send_beat(input int v, input bit last);
    bit rdy;
    int n = 0;
    in_valid = 1'b1;
    in_llr   = 12'(v);
    in_last  = last;
    forever begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      if (rdy) break;
      n++;
      if (n > 200) break;
    end
    if (rdy) model_accept(v, last);
    else check("beat_accept_timeout", 0, 1);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input int nbeats, input int last_at, input int mode);
    int dir[6] = '{2047, -2048, 127, -127, -128, 5};
    int v;
    for (int k = 0; k < nbeats; k++) begin
      if (mode == 0) v = k - 48;
      else if (mode == 1 && k < 6) v = dir[k];
      else v = int'($urandom_range(0, 4095)) - 2048;
      send_beat(v, k == last_at);
      if (k != nbeats - 1) begin
        repeat ($urandom_range(0, 1)) begin
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic take_frame();
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = frame_valid;
    end
    if (!seen) check("frame_valid_seen", 0, 1);
    @(posedge clk);
    #1 frame_ready = 1'b1;
    @(posedge clk);
    #1 frame_ready = 1'b0;
  endtask

  task automatic pulse_release();
    dec_release = 1'b1;
    @(posedge clk);
    #1 dec_release = 1'b0;
  endtask

  task automatic wait_ready();
    bit seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = in_ready;
    end
    check("in_ready_rises", int'(seen), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_wren", int'(wren), 0);
    check("rst_wraddress", int'(wraddress), 0);
    check("rst_data", int'(data), 0);
    check("rst_frame_valid", int'(frame_valid), 0);
    check("rst_frame_bank", int'(frame_bank), 0);
    check("rst_err_len", int'(err_len), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Frame 1: ramp into bank 0, offer appears two cycles after the last accept.
    send_frame(FRAME_LEN, FRAME_LEN - 1, 0);
    @(negedge clk);
    check("fv_one_cycle_after_last", int'(frame_valid), 0);
    @(negedge clk);
    check("fv_two_cycles_after_last", int'(frame_valid), 1);
    check("fv_bank0", int'(frame_bank), 0);
    @(posedge clk);
    #1;

    // Frame 2: saturation cases into bank 1, then both banks are held.
    send_frame(FRAME_LEN, FRAME_LEN - 1, 1);
    repeat (3) @(posedge clk);
    #1;
    pulse_release();
    repeat (2) @(negedge clk);
    check("full_in_ready_low", int'(in_ready), 0);
    check("full_fv_held", int'(frame_valid), 1);
    check("full_fv_bank0", int'(frame_bank), 0);
    @(posedge clk);
    #1;

    take_frame();
    @(negedge clk);
    check("after_take_fv", int'(frame_valid), 1);
    check("after_take_bank1", int'(frame_bank), 1);
    @(posedge clk);
    #1;
    pulse_release();
    wait_ready();

    // Frame 3 reuses bank 0.
    send_frame(FRAME_LEN, FRAME_LEN - 1, 2);
    take_frame();
    take_frame();
    // Oldest busy bank is bank 1, which is also the next write bank.
    pulse_release();
    wait_ready();

    // Short frame, then a frame missing its last marker.
    send_frame(41, 40, 2);
    @(negedge clk);
    check("short_err_len", int'(err_len), 1);
    check("short_no_fv", int'(frame_valid), 0);
    @(posedge clk);
    #1;
    send_frame(FRAME_LEN, -1, 2);
    @(negedge clk);
    check("nolast_err_len", int'(err_len), 1);
    @(posedge clk);
    #1;
    pulse_release();
    wait_ready();

    // Reset mid-frame.
    send_frame(50, -1, 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    exp_wr.delete();
    exp_fr.delete();
    wr_m  = 0;
    idx_m = 0;
    @(posedge clk);
    #1;

    send_frame(FRAME_LEN, FRAME_LEN - 1, 2);
    @(negedge clk);
    check("post_rst_fv_early", int'(frame_valid), 0);
    @(negedge clk);
    check("post_rst_fv", int'(frame_valid), 1);
    check("post_rst_bank0", int'(frame_bank), 0);
    @(posedge clk);
    #1;
    take_frame();
    repeat (4) @(posedge clk);
    check("writes_drained", exp_wr.size(), 0);
    check("frames_drained", exp_fr.size(), 0);
    check("err_len_count", obs_err, exp_err);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
